// File: rtl/eta1_pkg.sv
// Shared definitions for the ETA1 approximate adder and its error monitor.
package eta1_pkg;

  localparam int unsigned ETA1_WIDTH       = 32;
  localparam int unsigned ETA1_APPROX_BITS = 20;
  localparam int unsigned ETA1_BLOCK       = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } eta1_state_e;

endpackage

// File: rtl/eta1_err_calc.sv
// Three-register pipeline: exact result, signed difference, absolute error distance.
module eta1_err_calc
  import eta1_pkg::*;
#(
  parameter int unsigned WIDTH = ETA1_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic [WIDTH-1:0] approx_sum,
  output logic             out_valid,
  output logic [WIDTH:0]   ed
);

  logic [WIDTH-1:0] exact_d, exact_q, approx_q;
  logic [WIDTH:0]   diff_q, ed_q;
  logic             v1_q, v2_q, v3_q;

  // Borrow-out of the subtract path is dropped, mirroring the adder's wrap.
  assign exact_d = (op == OP_SUB) ? (a + ~b + WIDTH'(1)) : (a + b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_q  <= '0;
      approx_q <= '0;
      diff_q   <= '0;
      ed_q     <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
    end else begin
      v1_q     <= in_valid;
      exact_q  <= exact_d;
      approx_q <= approx_sum;
      v2_q     <= v1_q;
      diff_q   <= {1'b0, exact_q} - {1'b0, approx_q};
      v3_q     <= v2_q;
      ed_q     <= diff_q[WIDTH] ? (-diff_q) : diff_q;
    end
  end

  assign out_valid = v3_q;
  assign ed        = ed_q;

endmodule

// File: rtl/eta1_error_monitor.sv
// Run-based error statistics for the ETA1 adder: count, max distance, saturating sum.
module eta1_error_monitor
  import eta1_pkg::*;
#(
  parameter int unsigned WIDTH = ETA1_WIDTH,
  parameter int unsigned NSAMP = 1024,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic [WIDTH-1:0] approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_err,
  output logic [ACC_W-1:0] sum_abs_err
);

  localparam logic [CNT_W-1:0] NSampCnt = CNT_W'(NSAMP);
  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(NSAMP - 1);

  eta1_state_e      state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
  logic [WIDTH:0]   max_err_q, max_err_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W:0]   sum_ext;
  logic [WIDTH:0]   ed;
  logic             ed_valid, accept, clear;

  eta1_err_calc #(
    .WIDTH(WIDTH)
  ) u_err_calc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .a         (a),
    .b         (b),
    .op        (op),
    .approx_sum(approx_sum),
    .out_valid (ed_valid),
    .ed        (ed)
  );

  assign in_ready = (state_q == StRun) && (sample_cnt_q < NSampCnt);
  assign accept   = in_valid && in_ready;
  assign clear    = start && ((state_q == StIdle) || (state_q == StDone));
  assign sum_ext  = {1'b0, sum_q} + (ACC_W + 1)'(ed);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun: begin
        if (accept && (sample_cnt_q == LastCnt)) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end
      end
      StDrain: begin
        // Three cycles here cover the pipeline depth, so stats are final on entry to DONE.
        if (drain_q == 2'd2) state_d = StDone;
        else                 drain_d = drain_q + 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    max_err_d    = max_err_q;
    sum_d        = sum_q;
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      max_err_d    = '0;
      sum_d        = '0;
    end else begin
      if (accept) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (ed_valid) begin
        err_cnt_d = err_cnt_q + CNT_W'(ed != '0);
        if (ed > max_err_q) max_err_d = ed;
        sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      drain_q      <= 2'd0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_err_q    <= '0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_err_q    <= max_err_d;
      sum_q        <= sum_d;
    end
  end

  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign max_err     = max_err_q;
  assign sum_abs_err = sum_q;

endmodule

// File: tb/tb_eta1_error_monitor.sv
// Randomized and directed bench for eta1_error_monitor against a run-level statistics model.
module tb_eta1_error_monitor;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSAMP = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ACC_W = 33;
  localparam longint unsigned SumMax = (64'd1 << ACC_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              op = 1'b0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic [WIDTH-1:0]  approx_sum = '0;
  logic              in_ready, busy, done;
  logic [CNT_W-1:0]  sample_cnt, err_cnt;
  logic [WIDTH:0]    max_err;
  logic [ACC_W-1:0]  sum_abs_err;

  int checks = 0;
  int errors = 0;

  int unsigned     m_cnt, m_err;
  longint unsigned m_max, m_sum;

  typedef struct {
    int unsigned     e;
    longint unsigned mx;
    longint unsigned s;
  } snap_t;

  eta1_error_monitor #(
    .WIDTH(WIDTH),
    .NSAMP(NSAMP),
    .CNT_W(CNT_W),
    .ACC_W(ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .approx_sum (approx_sum),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .max_err    (max_err),
    .sum_abs_err(sum_abs_err)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned ref_exact(input logic [31:0] x, input logic [31:0] y,
                                                input logic o);
    if (o) return (64'(x) + 64'h1_0000_0000 - 64'(y)) & 64'hFFFF_FFFF;
    return (64'(x) + 64'(y)) & 64'hFFFF_FFFF;
  endfunction

  function automatic longint unsigned ref_ed(input logic [31:0] x, input logic [31:0] y,
                                             input logic o, input logic [31:0] ap);
    longint unsigned ex;
    ex = ref_exact(x, y, o);
    return (ex >= 64'(ap)) ? ex - 64'(ap) : 64'(ap) - ex;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0;
  endtask

  task automatic model_accept(input logic [31:0] x, input logic [31:0] y, input logic o,
                              input logic [31:0] ap);
    longint unsigned ed;
    ed = ref_ed(x, y, o, ap);
    m_cnt++;
    if (ed != 0) m_err++;
    if (ed > m_max) m_max = ed;
    m_sum = (m_sum + ed > SumMax) ? SumMax : m_sum + ed;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic o,
                      input logic [31:0] ap);
    a = x; b = y; op = o; approx_sum = ap; in_valid = 1'b1;
    model_accept(x, y, o, ap);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        n = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, in_ready, sample_cnt, err_cnt, max_err, sum_abs_err} !== '0) begin
      errors++;
      $display("FAIL reset_held: busy=%0b done=%0b rdy=%0b cnt=%0d err=%0d max=%0h sum=%0h want 0",
               busy, done, in_ready, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, in_ready, sample_cnt, err_cnt, max_err, sum_abs_err} !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b done=%0b rdy=%0b cnt=%0d err=%0d want all 0",
               busy, done, in_ready, sample_cnt, err_cnt);
    end
  endtask

  task automatic test_lost_carry();
    int n;
    start_run();
    checks++;
    if ({busy, in_ready, done, sample_cnt} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL run_entry: busy=%0b rdy=%0b done=%0b cnt=%0d want 1 1 0 0",
               busy, in_ready, done, sample_cnt);
    end
    send(32'h000F_FFFF, 32'h1, 1'b0, 32'h000F_FFFF);
    send(32'd10, 32'd20, 1'b0, 32'd30);
    send(32'd100, 32'd1, 1'b1, 32'd99);
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
    wait_done(n);
    checks++;
    if (n < 0 || {sample_cnt, err_cnt, max_err, sum_abs_err} !==
        {16'd4, 16'd1, 33'd1, 33'd1}) begin
      errors++;
      $display("FAIL lost_carry: done_wait=%0d cnt=%0d err=%0d max=%0h sum=%0h want 4 1 1 1",
               n, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
  endtask

  task automatic test_upper_carry();
    int n;
    start_run();
    send(32'h0008_0000, 32'h0008_0000, 1'b0, 32'h000F_FFFF);
    send(32'd5, 32'd3, 1'b1, 32'd2);
    send(32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF);
    send(32'h1234, 32'h4321, 1'b0, 32'h5555);
    wait_done(n);
    checks++;
    if (n < 0 || {sample_cnt, err_cnt, max_err, sum_abs_err} !==
        {16'd4, 16'd1, 33'd1, 33'd1}) begin
      errors++;
      $display("FAIL upper_carry: done_wait=%0d cnt=%0d err=%0d max=%0h sum=%0h want 4 1 1 1",
               n, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
  endtask

  task automatic test_bubbles();
    int pat[6] = '{1, 0, 1, 1, 0, 1};
    int xfers = 0;
    start_run();
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i][0];
      a = 32'(i); b = 32'd1; op = 1'b0; approx_sum = 32'(i + 1);
      if (in_valid && in_ready) xfers++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (xfers != 4 || in_ready !== 1'b0 || sample_cnt !== 16'd4) begin
      errors++;
      $display("FAIL bubbles_xfer: xfers=%0d rdy=%0b cnt=%0d want 4 0 4", xfers, in_ready,
               sample_cnt);
    end
    step();
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bubbles_drain: done=%0b busy=%0b two edges after last accept want 0 1",
               done, busy);
    end
    step();
    checks++;
    if ({done, busy, err_cnt, max_err, sum_abs_err} !== {1'b1, 1'b0, 16'd0, 33'd0, 33'd0}) begin
      errors++;
      $display("FAIL bubbles_done: done=%0b busy=%0b err=%0d max=%0h sum=%0h want 1 0 0 0 0",
               done, busy, err_cnt, max_err, sum_abs_err);
    end
  endtask

  task automatic test_saturation();
    int n;
    start_run();
    repeat (4) send(32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF);
    wait_done(n);
    checks++;
    if (n < 0 || {sample_cnt, err_cnt, max_err, sum_abs_err} !==
        {16'd4, 16'd4, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF}) begin
      errors++;
      $display("FAIL saturation: done_wait=%0d cnt=%0d err=%0d max=%0h sum=%0h want 4 4 ffffffff 1ffffffff",
               n, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
    repeat (3) step();
    checks++;
    if (sum_abs_err !== 33'h1_FFFF_FFFF || done !== 1'b1) begin
      errors++;
      $display("FAIL saturation_hold: sum=%0h done=%0b want 1ffffffff 1", sum_abs_err, done);
    end
  endtask

  task automatic test_restart();
    int n;
    start = 1'b1; in_valid = 1'b1; a = 32'd1; b = 32'd1; op = 1'b0; approx_sum = 32'd0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_ready: in_ready=%0b with start in DONE want 0", in_ready);
    end
    step();
    start = 1'b0; in_valid = 1'b0;
    model_clear();
    checks++;
    if ({busy, sample_cnt, err_cnt, max_err, sum_abs_err} !== {1'b1, 16'd0, 16'd0, 33'd0, 33'd0})
    begin
      errors++;
      $display("FAIL restart_clear: busy=%0b cnt=%0d err=%0d max=%0h sum=%0h want 1 0 0 0 0",
               busy, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
    send(32'd7, 32'd0, 1'b0, 32'd5);
    send(32'd10, 32'd3, 1'b1, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if ({busy, sample_cnt, err_cnt, max_err, sum_abs_err} !== {1'b1, 16'd2, 16'd2, 33'd7, 33'd9})
    begin
      errors++;
      $display("FAIL start_in_run: busy=%0b cnt=%0d err=%0d max=%0h sum=%0h want 1 2 2 7 9",
               busy, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
    send(32'd1, 32'd1, 1'b0, 32'd2);
    send(32'd0, 32'd0, 1'b1, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n < 0 || {sample_cnt, err_cnt, max_err, sum_abs_err} !==
        {16'd4, 16'd2, 33'd7, 33'd9}) begin
      errors++;
      $display("FAIL restart_run: done_wait=%0d cnt=%0d err=%0d max=%0h sum=%0h want 4 2 7 9",
               n, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
  endtask

  task automatic test_random(input int runs);
    snap_t q[$];
    snap_t cur, exp_s;
    logic [31:0] x, y, ex, ap;
    logic o, v, acc;
    int last_acc;
    bit finished;
    for (int r = 0; r < runs; r++) begin
      start_run();
      q.delete();
      cur = '{e: 0, mx: 0, s: 0};
      q.push_back(cur);
      last_acc = -100;
      finished = 1'b0;
      for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
        x = $urandom; y = $urandom; o = 1'($urandom_range(0, 1));
        ex = 32'(ref_exact(x, y, o));
        case ($urandom_range(0, 3))
          0, 1:    ap = ex;
          2:       ap = ex ^ (32'd1 << $urandom_range(0, 31));
          default: ap = $urandom;
        endcase
        v = ($urandom_range(0, 3) != 0);
        a = x; b = y; op = o; approx_sum = ap; in_valid = v;
        acc = v && (m_cnt < NSAMP);
        checks++;
        if (in_ready !== (m_cnt < NSAMP)) begin
          errors++;
          $display("FAIL rand_ready: run %0d cyc %0d in_ready=%0b want %0b", r, cyc, in_ready,
                   m_cnt < NSAMP);
        end
        step();
        if (acc) begin
          model_accept(x, y, o, ap);
          last_acc = cyc;
        end
        cur = '{e: m_err, mx: m_max, s: m_sum};
        q.push_back(cur);
        if (q.size() > 3) begin
          exp_s = q.pop_front();
          checks++;
          if ({err_cnt, max_err, sum_abs_err} !==
              {CNT_W'(exp_s.e), 33'(exp_s.mx), 33'(exp_s.s)}) begin
            errors++;
            $display("FAIL rand_stats: run %0d cyc %0d err=%0d max=%0h sum=%0h want %0d %0h %0h",
                     r, cyc, err_cnt, max_err, sum_abs_err, exp_s.e, exp_s.mx, exp_s.s);
          end
        end
        checks++;
        if (sample_cnt !== CNT_W'(m_cnt) ||
            done !== ((m_cnt == NSAMP) && (cyc >= last_acc + 3))) begin
          errors++;
          $display("FAIL rand_ctrl: run %0d cyc %0d cnt=%0d done=%0b want %0d %0b", r, cyc,
                   sample_cnt, done, m_cnt, (m_cnt == NSAMP) && (cyc >= last_acc + 3));
        end
        if (m_cnt == NSAMP && cyc == last_acc + 3) finished = 1'b1;
      end
      in_valid = 1'b0;
      if (!finished) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: run %0d did not complete within 200 cycles", r);
      end
    end
  endtask

  task automatic test_reset_midrun();
    start_run();
    send(32'h0, 32'h0, 1'b0, 32'h0000_0100);
    send(32'h5, 32'h5, 1'b0, 32'h0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, in_ready, sample_cnt, err_cnt, max_err, sum_abs_err} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%0b cnt=%0d err=%0d max=%0h sum=%0h want all 0",
               busy, sample_cnt, err_cnt, max_err, sum_abs_err);
    end
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if ({busy, done, in_ready, sample_cnt, err_cnt, max_err, sum_abs_err} !== '0) begin
      errors++;
      $display("FAIL reset_midrun_idle: busy=%0b rdy=%0b cnt=%0d err=%0d want idle zeros",
               busy, in_ready, sample_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lost_carry();
    test_upper_carry();
    test_bubbles();
    test_saturation();
    test_restart();
    test_random(20);
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
